uart_cmd_parser: RTL and testbench

UART_CMD_PARSER -- requirements
Module: uart_cmd_parser

---
 rtl/uart_cmd_parser.sv | 170 +++++++++++++++++
 tb/tb_uart_cmd_parser.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_parser.sv
`default_nettype none
// ============================================================================
// Module   : uart_cmd_parser
// Purpose  : Parses 4-byte command frames (SOF, CMD, ARG, CHK) from a UART
//            receive FIFO. A frame is good when CHK = CMD ^ ARG. Good frames
//            update cmd/arg, pulse cmd_valid and queue an ACK byte. Frames
//            with a bad checksum pulse frame_err and queue a NAK byte.
// Ports    : clk        - clock, rising edge
//            reset      - synchronous active-high reset
//            rx_empty   - receive FIFO empty flag
//            r_data     - receive FIFO head byte
//            rd_uart    - receive FIFO pop strobe
//            tx_full    - transmit FIFO full flag
//            wr_uart    - transmit FIFO push strobe
//            w_data     - response byte (ACK/NAK), 8'h00 when not writing
//            cmd, arg   - command/argument of the last good frame
//            cmd_valid  - one-cycle pulse per good frame
//            frame_err  - one-cycle pulse per bad checksum or timeout
// Options  : UART_PARSER_TIMEOUT_EN - when defined, a stalled partial frame
//            is abandoned after TIMEOUT idle cycles (counter TIMEOUT_BIT
//            wide); when undefined the parser waits indefinitely.
// Revision : 1.0 - initial release
// ============================================================================
module uart_cmd_parser #(
   parameter logic [7:0] SOF         = 8'h55,
   parameter logic [7:0] ACK         = 8'h06,
   parameter logic [7:0] NAK         = 8'h15,
   parameter int         TIMEOUT     = 50000,
   parameter int         TIMEOUT_BIT = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx_empty,
   input  logic [7:0] r_data,
   output logic       rd_uart,
   input  logic       tx_full,
   output logic       wr_uart,
   output logic [7:0] w_data,
   output logic [7:0] cmd,
   output logic [7:0] arg,
   output logic       cmd_valid,
   output logic       frame_err
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_GET_CMD = 3'd1;
   localparam logic [2:0] S_GET_ARG = 3'd2;
   localparam logic [2:0] S_GET_CHK = 3'd3;
   localparam logic [2:0] S_RESP    = 3'd4;

   logic [2:0] state;
   logic [7:0] cmd_sh;
   logic [7:0] arg_sh;
   logic       good;
   logic       in_rx;
   logic       in_get;
   logic       chk_ok;
   logic       timeout_hit;

   // The timeout counter must be able to hold TIMEOUT-1.
   if (TIMEOUT < 2 || TIMEOUT > (2 ** TIMEOUT_BIT)) begin : g_cfg_check
      $error("uart_cmd_parser: TIMEOUT does not fit in TIMEOUT_BIT bits");
   end

   assign in_rx  = (state == S_IDLE) || (state == S_GET_CMD) ||
                   (state == S_GET_ARG) || (state == S_GET_CHK);
   assign in_get = (state == S_GET_CMD) || (state == S_GET_ARG) ||
                   (state == S_GET_CHK);

   // Pop whenever a byte is available in a receiving state; the byte is
   // consumed by the state register on the same edge.
   assign rd_uart = ~reset & in_rx & ~rx_empty;

   // Response is combinational so it lands in the first cycle tx_full is low.
   assign wr_uart = ~reset & (state == S_RESP) & ~tx_full;
   assign w_data  = wr_uart ? (good ? ACK : NAK) : 8'h00;

   assign chk_ok  = (r_data == (cmd_sh ^ arg_sh));

`ifdef UART_PARSER_TIMEOUT_EN
   localparam logic [TIMEOUT_BIT-1:0] TO_LAST = TIMEOUT_BIT'(TIMEOUT - 1);
   localparam logic [TIMEOUT_BIT-1:0] TO_ONE  = TIMEOUT_BIT'(1);

   logic [TIMEOUT_BIT-1:0] to_cnt;

   assign timeout_hit = in_get & rx_empty & (to_cnt == TO_LAST);

   // Counts consecutive empty cycles mid-frame; any pop restarts the gap.
   always_ff @(posedge clk) begin
      if (reset) begin
         to_cnt <= '0;
      end else if (!in_get || rd_uart || timeout_hit) begin
         to_cnt <= '0;
      end else if (rx_empty) begin
         to_cnt <= to_cnt + TO_ONE;
      end
   end
`else
   assign timeout_hit = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         cmd_sh    <= 8'h00;
         arg_sh    <= 8'h00;
         good      <= 1'b0;
         cmd       <= 8'h00;
         arg       <= 8'h00;
         cmd_valid <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         cmd_valid <= 1'b0;
         frame_err <= 1'b0;
         case (state)
            S_IDLE: begin
               // Non-SOF bytes are popped and dropped here.
               if (rd_uart && (r_data == SOF)) begin
                  state <= S_GET_CMD;
               end
            end
            S_GET_CMD: begin
               // An SOF-valued byte is a legal command; no resync.
               if (timeout_hit) begin
                  frame_err <= 1'b1;
                  state     <= S_IDLE;
               end else if (rd_uart) begin
                  cmd_sh <= r_data;
                  state  <= S_GET_ARG;
               end
            end
            S_GET_ARG: begin
               if (timeout_hit) begin
                  frame_err <= 1'b1;
                  state     <= S_IDLE;
               end else if (rd_uart) begin
                  arg_sh <= r_data;
                  state  <= S_GET_CHK;
               end
            end
            S_GET_CHK: begin
               if (timeout_hit) begin
                  frame_err <= 1'b1;
                  state     <= S_IDLE;
               end else if (rd_uart) begin
                  good  <= chk_ok;
                  state <= S_RESP;
                  if (chk_ok) begin
                     cmd       <= cmd_sh;
                     arg       <= arg_sh;
                     cmd_valid <= 1'b1;
                  end else begin
                     frame_err <= 1'b1;
                  end
               end
            end
            S_RESP: begin
               if (!tx_full) begin
                  state <= S_IDLE;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_parser.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_cmd_parser
// Purpose  : Self-checking bench for uart_cmd_parser. Models both UART FIFOs
//            with queues, predicts responses by scanning the byte stream for
//            frames, and compares recorded DUT events against the prediction.
// Options  : UART_PARSER_TIMEOUT_EN - also exercises the inter-byte timeout
//            with TIMEOUT=100.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_cmd_parser;

   localparam logic [7:0] SOF_B = 8'h55;
   localparam logic [7:0] ACK_B = 8'h06;
   localparam logic [7:0] NAK_B = 8'h15;
`ifdef UART_PARSER_TIMEOUT_EN
   localparam int TB_TIMEOUT = 100;
`else
   localparam int TB_TIMEOUT = 50000;
`endif

   typedef struct {
      logic       good;
      logic [7:0] c;
      logic [7:0] a;
   } res_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       rx_empty = 1'b1;
   logic [7:0] r_data = 8'h00;
   logic       rd_uart;
   logic       tx_full = 1'b0;
   logic       wr_uart;
   logic [7:0] w_data;
   logic [7:0] cmd;
   logic [7:0] arg;
   logic       cmd_valid;
   logic       frame_err;

   uart_cmd_parser #(
      .SOF        (SOF_B),
      .ACK        (ACK_B),
      .NAK        (NAK_B),
      .TIMEOUT    (TB_TIMEOUT),
      .TIMEOUT_BIT(16)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .rx_empty (rx_empty),
      .r_data   (r_data),
      .rd_uart  (rd_uart),
      .tx_full  (tx_full),
      .wr_uart  (wr_uart),
      .w_data   (w_data),
      .cmd      (cmd),
      .arg      (arg),
      .cmd_valid(cmd_valid),
      .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   // Bench state
   logic [7:0]  rx_q[$];
   logic [7:0]  stim_q[$];
   logic [7:0]  wr_q[$];
   logic [15:0] cv_q[$];
   int          fe_n;
   int          rd_n;
   int          viol;
   logic        pop_pend = 1'b0;
   logic        reset_v  = 1'b1;
   logic        tx_full_v = 1'b0;
   logic        rand_tx  = 1'b0;
   logic        last_wr;
   logic [7:0]  last_wd;
   logic [7:0]  exp_cmd = 8'h00;
   logic [7:0]  exp_arg = 8'h00;
   int          n_checks = 0;
   int          n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // One clock: apply FIFO pop from last cycle, drive inputs after the
   // falling edge, then sample outputs 1 ns later (well before the rising edge).
   task automatic step();
      logic [7:0] tmp;
      @(negedge clk);
      if (pop_pend && rx_q.size() > 0) tmp = rx_q.pop_front();
      pop_pend = 1'b0;
      rx_empty = (rx_q.size() == 0);
      r_data   = rx_empty ? 8'h00 : rx_q[0];
      tx_full  = rand_tx ? ($urandom_range(0, 3) == 0) : tx_full_v;
      reset    = reset_v;
      #1;
      pop_pend = rd_uart;
      last_wr  = wr_uart;
      last_wd  = w_data;
      if (rd_uart && rx_empty)        viol++;
      if (rd_uart && wr_uart)         viol++;
      if (!wr_uart && w_data !== 8'h00) viol++;
      if (wr_uart && tx_full)         viol++;
      if (reset && rd_uart)           viol++;
      if (rd_uart)   rd_n++;
      if (wr_uart)   wr_q.push_back(w_data);
      if (cmd_valid) cv_q.push_back({cmd, arg});
      if (frame_err) fe_n++;
   endtask

   task automatic clear_rec();
      wr_q.delete();
      cv_q.delete();
      fe_n = 0;
      rd_n = 0;
   endtask

   // Reference: scan the stream; an SOF starts a 4-byte frame, anything
   // else outside a frame is junk.
   task automatic feed_and_run(input string tag, input int cycles);
      res_t exp_q[$];
      res_t r;
      int   i;
      int   bad;
      int   good_n;
      i = 0;
      bad = 0;
      good_n = 0;
      while (i < stim_q.size()) begin
         if (stim_q[i] == SOF_B && i + 3 < stim_q.size()) begin
            r.c    = stim_q[i+1];
            r.a    = stim_q[i+2];
            r.good = (stim_q[i+3] == (r.c ^ r.a));
            exp_q.push_back(r);
            i += 4;
         end else begin
            i++;
         end
      end
      clear_rec();
      foreach (stim_q[k]) rx_q.push_back(stim_q[k]);
      repeat (cycles) step();

      check({tag, "_rx_drained"}, rx_q.size(), 0);
      check({tag, "_resp_count"}, wr_q.size(), exp_q.size());
      for (int k = 0; k < exp_q.size() && k < wr_q.size(); k++)
         check($sformatf("%s_resp%0d", tag, k), wr_q[k], exp_q[k].good ? ACK_B : NAK_B);
      foreach (exp_q[k]) begin
         if (exp_q[k].good) begin
            if (good_n < cv_q.size())
               check($sformatf("%s_cv%0d", tag, good_n), cv_q[good_n], {exp_q[k].c, exp_q[k].a});
            good_n++;
            exp_cmd = exp_q[k].c;
            exp_arg = exp_q[k].a;
         end else begin
            bad++;
         end
      end
      check({tag, "_cmd_valid_count"}, cv_q.size(), good_n);
      check({tag, "_frame_err_count"}, fe_n, bad);
      check({tag, "_cmd"}, cmd, exp_cmd);
      check({tag, "_arg"}, arg, exp_arg);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_rd_uart"},   rd_uart,   0);
      check({tag, "_wr_uart"},   wr_uart,   0);
      check({tag, "_w_data"},    w_data,    0);
      check({tag, "_cmd"},       cmd,       0);
      check({tag, "_arg"},       arg,       0);
      check({tag, "_cmd_valid"}, cmd_valid, 0);
      check({tag, "_frame_err"}, frame_err, 0);
   endtask

   initial begin
      viol = 0;
      clear_rec();

      // Reset state
      reset_v = 1'b1;
      step();
      step();
      check_reset_outputs("por");
      reset_v = 1'b0;
      step();

      // Good frame
      stim_q = '{8'h55, 8'h12, 8'h34, 8'h26};
      feed_and_run("good", 20);

      // Bad checksum: cmd/arg must keep 12/34
      stim_q = '{8'h55, 8'h12, 8'h34, 8'h00};
      feed_and_run("badchk", 20);

      // Junk discard and SOF-valued command byte
      stim_q = '{8'h00, 8'hFF, 8'h55, 8'h55, 8'h01, 8'h54};
      feed_and_run("junk", 24);

      // Transmit back-pressure with a second frame already queued
      clear_rec();
      tx_full_v = 1'b1;
      rx_q = '{8'h55, 8'h12, 8'h34, 8'h26, 8'h55, 8'h01, 8'h02, 8'h03};
      repeat (4) step();
      rd_n = 0;
      repeat (20) step();
      check("bp_rd_held", rd_n, 0);
      check("bp_wr_held", wr_q.size(), 0);
      check("bp_pending", rx_q.size(), 4);
      check("bp_cv_once", cv_q.size(), 1);
      tx_full_v = 1'b0;
      step();
      check("bp_wr_first", last_wr, 1);
      check("bp_wd_first", last_wd, ACK_B);
      repeat (20) step();
      check("bp_resp_count", wr_q.size(), 2);
      if (wr_q.size() == 2) check("bp_resp2", wr_q[1], ACK_B);
      check("bp_cv_count", cv_q.size(), 2);
      if (cv_q.size() == 2) check("bp_cv2", cv_q[1], 16'h0102);
      exp_cmd = 8'h01;
      exp_arg = 8'h02;

`ifdef UART_PARSER_TIMEOUT_EN
      // Stalled frame is abandoned silently, then a new frame is accepted
      clear_rec();
      rx_q = '{8'h55, 8'h12};
      repeat (115) step();
      check("to_frame_err", fe_n, 1);
      check("to_no_resp", wr_q.size(), 0);
      check("to_no_cv", cv_q.size(), 0);
      stim_q = '{8'h55, 8'h01, 8'h02, 8'h03};
      feed_and_run("after_to", 20);
`endif

      // Reset mid-frame discards the partial frame
      clear_rec();
      rx_q = '{8'h55, 8'h12};
      repeat (2) step();
      reset_v = 1'b1;
      rx_q.push_back(8'h77);
      step();
      check("rst_rd_forced", rd_uart, 0);
      step();
      check_reset_outputs("midrst");
      reset_v = 1'b0;
      rx_q.delete();
      pop_pend = 1'b0;
      exp_cmd = 8'h00;
      exp_arg = 8'h00;
      step();
      stim_q = '{8'h55, 8'hAA, 8'hBB, 8'h11};
      feed_and_run("post_rst", 20);

      // Random frames with junk and random transmit back-pressure
      for (int t = 0; t < 4; t++) begin
         logic [7:0] c, a, b;
         stim_q.delete();
         for (int f = 0; f < 8; f++) begin
            for (int j = 0, nj = $urandom_range(0, 2); j < nj; j++) begin
               b = 8'($urandom_range(0, 255));
               stim_q.push_back((b == SOF_B) ? 8'h00 : b);
            end
            c = 8'($urandom_range(0, 255));
            a = 8'($urandom_range(0, 255));
            b = ($urandom_range(0, 1) == 1) ? (c ^ a) : (c ^ a ^ 8'($urandom_range(1, 255)));
            stim_q.push_back(SOF_B);
            stim_q.push_back(c);
            stim_q.push_back(a);
            stim_q.push_back(b);
         end
         rand_tx = 1'b1;
         feed_and_run($sformatf("rand%0d", t), 8 * stim_q.size() + 40);
         rand_tx = 1'b0;
      end

      check("protocol_violations", viol, 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
